uart_tx_fifo_param: RTL and testbench

- Parametrised transmit-side buffer between the host/register interface and the UART transmitter.
- Supersedes the fixed 16x8, fill-then-drain TX buffer.
- Uses independent valid/ready handshakes on write and read sides, so writes and reads can run concurrently.
- Adds configurable width/depth, occupancy count, almost-full flag, sticky overflow flag and synchronous flush; keeps the clock-enable qualification of all transfers.

---
 rtl/uart_tx_fifo_param.sv | 86 ++++++++
 tb/tb_uart_tx_fifo_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// Parametrised TX-side FIFO feeding the UART transmitter.
// First-word fall-through, valid/ready on both sides, sticky overflow.
module uart_tx_fifo_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_clk,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_THRESH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign almost_full = (count >= AF_TH);
  assign overflow    = ovf_q;

  assign s_ready = !full && enable_clk;
  assign m_valid = !empty;
  assign m_data  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_fire = s_valid && s_ready && !flush;
  assign rd_fire = m_valid && m_ready && enable_clk && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      if (s_valid && full && enable_clk) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally not reset; m_data is ignored while empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param.
// Runs the same suite on a 8x16 and a 12x4 instance.
module tb_uart_tx_fifo_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [11:0] s_data;
  logic        s_valid;
  logic        m_ready;
  logic        sel;

  logic [7:0]  md0;
  logic [4:0]  cn0;
  logic        sr0, mv0, fu0, em0, af0, ov0;
  logic [11:0] md1;
  logic [2:0]  cn1;
  logic        sr1, mv1, fu1, em1, af1, ov1;

  logic [11:0] mdata;
  logic [8:0]  cnt;
  logic        sr, mv, fu, em, af, ov;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_param #(
    .WIDTH(8), .DEPTH(16), .AFULL_THRESH(14)
  ) u0 (
    .clk(clk), .rst(rst), .enable_clk(en), .flush(flush),
    .s_data(s_data[7:0]), .s_valid(s_valid), .s_ready(sr0),
    .m_data(md0), .m_valid(mv0), .m_ready(m_ready),
    .count(cn0), .full(fu0), .empty(em0),
    .almost_full(af0), .overflow(ov0)
  );

  uart_tx_fifo_param #(
    .WIDTH(12), .DEPTH(4), .AFULL_THRESH(3)
  ) u1 (
    .clk(clk), .rst(rst), .enable_clk(en), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(sr1),
    .m_data(md1), .m_valid(mv1), .m_ready(m_ready),
    .count(cn1), .full(fu1), .empty(em1),
    .almost_full(af1), .overflow(ov1)
  );

  always_comb begin
    if (sel) begin
      mdata = md1;
      cnt   = {6'd0, cn1};
      sr = sr1; mv = mv1; fu = fu1;
      em = em1; af = af1; ov = ov1;
    end else begin
      mdata = {4'd0, md0};
      cnt   = {4'd0, cn0};
      sr = sr0; mv = mv0; fu = fu0;
      em = em0; af = af0; ov = ov0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cfg %0d): got %0h expected %0h",
               tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_data  = 12'(base + i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_suite();
    int D;
    int th;
    int n;
    int nxt;
    int q[$];
    logic wf;
    logic rf;
    D  = sel ? 4 : 16;
    th = sel ? 3 : 14;

    // reset state
    s_valid = 0; m_ready = 0; flush = 0;
    en = 1; s_data = 0; rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_count", 32'(cnt), 0);
    chk("rst_empty", 32'(em), 1);
    chk("rst_full", 32'(fu), 0);
    chk("rst_afull", 32'(af), 0);
    chk("rst_ovf", 32'(ov), 0);
    chk("rst_mvalid", 32'(mv), 0);
    chk("rst_sready", 32'(sr), 1);

    // three writes, latency, async reset
    for (int i = 0; i < 3; i++) begin
      s_data  = 12'(12'h11 * (i + 1));
      s_valid = 1'b1;
      #1;
      if (i == 0) chk("no_bypass", 32'(mv), 0);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("w3_count", 32'(cnt), 3);
    chk("w3_head", 32'(mdata), 32'h11);
    chk("w3_mvalid", 32'(mv), 1);
    chk("w3_empty", 32'(em), 0);
    chk("w3_afull", 32'(af), 32'(3 >= th));
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 0);
    chk("async_rst_mv", 32'(mv), 0);
    tick();
    rst = 1'b0;

    // fill to full, overflow, drain in order
    for (int i = 0; i < D; i++) begin
      s_data  = 12'(i);
      s_valid = 1'b1;
      tick();
      chk("fill_count", 32'(cnt), 32'(i + 1));
      chk("fill_afull", 32'(af), 32'((i + 1) >= th));
    end
    chk("full_flag", 32'(fu), 1);
    chk("full_sready", 32'(sr), 0);
    chk("pre_ovf", 32'(ov), 0);
    tick();
    s_valid = 1'b0;
    chk("ovf_set", 32'(ov), 1);
    chk("ovf_count", 32'(cnt), 32'(D));
    m_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      chk("drain_mv", 32'(mv), 1);
      chk("drain_data", 32'(mdata), 32'(i));
      tick();
    end
    m_ready = 1'b0;
    chk("drain_empty", 32'(em), 1);
    chk("ovf_sticky", 32'(ov), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovf", 32'(ov), 0);

    // streaming across several wraps
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s_data = 12'(k);
      #1;
      if (k > 0) begin
        chk("strm_data", 32'(mdata), 32'(k - 1));
        chk("strm_count", 32'(cnt), 1);
      end
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("strm_last", 32'(mdata), 39);
    tick();
    m_ready = 1'b0;
    chk("strm_empty", 32'(em), 1);

    // full with write and read in the same cycle
    fill(D, 'h40);
    s_data  = 12'hAA;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("fr_sready0", 32'(sr), 0);
    chk("fr_full", 32'(fu), 1);
    tick();
    chk("fr_count_rd", 32'(cnt), 32'(D - 1));
    m_ready = 1'b0;
    #1;
    chk("fr_sready1", 32'(sr), 1);
    tick();
    s_valid = 1'b0;
    chk("fr_count_wr", 32'(cnt), 32'(D));
    m_ready = 1'b1;
    for (int i = 0; i < D - 1; i++) begin
      #1;
      chk("fr_order", 32'(mdata), 32'('h41 + i));
      tick();
    end
    #1;
    chk("fr_tail", 32'(mdata), 32'hAA);
    tick();
    m_ready = 1'b0;
    chk("fr_empty", 32'(em), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // enable_clk active one cycle in four
    q.delete();
    nxt = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      en = (c % 4 == 0);
      s_data = 12'(nxt);
      #1;
      chk("en_sready", 32'(sr), 32'(en && q.size() < D));
      chk("en_count", 32'(cnt), 32'(q.size()));
      if (q.size() > 0) chk("en_data", 32'(mdata), 32'(q[0]));
      wf = en && (q.size() < D);
      rf = en && (q.size() > 0);
      tick();
      if (rf) void'(q.pop_front());
      if (wf) begin
        q.push_back(nxt);
        nxt++;
      end
    end
    chk("en_writes", 32'(nxt), 8);
    en = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("en0_sready", 32'(sr), 0);
    n = q.size();
    tick();
    chk("en0_frozen", 32'(cnt), 32'(n));
    chk("en0_mvalid", 32'(mv), 1);
    chk("en0_head", 32'(mdata), 7);
    en = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("en_drained", 32'(em), 1);

    // flush beats a concurrent write
    n = (D > 5) ? 5 : D - 1;
    fill(D, 'h60);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < D - n; i++) tick();
    m_ready = 1'b0;
    chk("fl_pre_count", 32'(cnt), 32'(n));
    chk("fl_pre_ovf", 32'(ov), 1);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 12'h77;
    tick();
    flush = 1'b0;
    s_valid = 1'b0;
    chk("fl_count", 32'(cnt), 0);
    chk("fl_empty", 32'(em), 1);
    chk("fl_ovf", 32'(ov), 0);
    chk("fl_mvalid", 32'(mv), 0);
    s_data = 12'h5A;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("fl_new_head", 32'(mdata), 32'h5A);
    chk("fl_new_count", 32'(cnt), 1);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    flush = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data = '0;
    sel = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      run_suite();
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
